// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings and parity modes.
// Also used by the matching receiver, so the encodings must stay stable.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    // Parity bit for a data word (zero-extended to 9 bits, which leaves the XOR unchanged).
    function automatic logic parity_bit(input logic [1:0] mode, input logic [8:0] word);
        logic p_s;
        case (mode)
            PAR_EVEN: p_s = ^word;
            PAR_ODD:  p_s = ~^word;
            PAR_MARK: p_s = 1'b1;
            default:  p_s = 1'b0;
        endcase
        return p_s;
    endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DBITS data bits LSB-first, runtime parity,
// 1 or 2 stop bits, valid/ready input handshake and break generation.
// Bit timing is OVERSAMPLE sample_ticks per bit from the shared baud generator.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DBITS      = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             sample_tick,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [DBITS-1:0] data_in,
    input  logic [1:0]       parity_mode,
    input  logic             stop2,
    input  logic             break_req,
    output logic             tx,
    output logic             tx_done,
    output logic             busy,
    output logic [2:0]       state_out
);

    localparam int TW = $clog2(2 * OVERSAMPLE);
    localparam int BW = ($clog2(DBITS) < 1) ? 1 : $clog2(DBITS);
    localparam logic [TW-1:0] BIT_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP2_LAST = TW'(2 * OVERSAMPLE - 1);
    localparam logic [BW-1:0] DBIT_LAST  = BW'(DBITS - 1);

    if (DBITS < 5 || DBITS > 9 || OVERSAMPLE < 2) begin : g_bad_param
        $error("uart_tx_cfg: DBITS must be 5..9 and OVERSAMPLE >= 2");
    end

    uart_state_t      state_r,    state_s;
    logic [TW-1:0]    tick_cnt_r, tick_cnt_s;
    logic [BW-1:0]    bit_cnt_r,  bit_cnt_s;
    logic [DBITS-1:0] shift_r,    shift_s;
    logic [DBITS-1:0] word_r,     word_s;
    logic [1:0]       par_mode_r, par_mode_s;
    logic             stop2_r,    stop2_s;
    logic             tx_r,       tx_s;
    logic             ready_s;
    logic             done_s;
    logic [TW-1:0]    stop_last_s;

    // Next-state, counter and line-level logic for the frame sequencer.
    always_comb begin
        state_s     = state_r;
        tick_cnt_s  = tick_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        word_s      = word_r;
        par_mode_s  = par_mode_r;
        stop2_s     = stop2_r;
        done_s      = 1'b0;
        ready_s     = (state_r == ST_IDLE) && !break_req;
        stop_last_s = stop2_r ? STOP2_LAST : BIT_LAST;

        case (state_r)
            ST_IDLE: begin
                // Break has priority over a pending frame.
                if (break_req) begin
                    state_s = ST_BREAK;
                end else if (tx_valid) begin
                    state_s    = ST_START;
                    tick_cnt_s = {TW{1'b0}};
                    bit_cnt_s  = {BW{1'b0}};
                    shift_s    = data_in;
                    word_s     = data_in;
                    par_mode_s = parity_mode;
                    stop2_s    = stop2;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (sample_tick && (tick_cnt_r == BIT_LAST)) begin
                    state_s    = ST_DATA;
                    tick_cnt_s = {TW{1'b0}};
                end else if (sample_tick) begin
                    tick_cnt_s = tick_cnt_r + TW'(1);
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            ST_DATA: begin
                if (sample_tick && (tick_cnt_r == BIT_LAST)) begin
                    tick_cnt_s = {TW{1'b0}};
                    shift_s    = {1'b0, shift_r[DBITS-1:1]};
                    if (bit_cnt_r == DBIT_LAST) begin
                        bit_cnt_s = {BW{1'b0}};
                        state_s   = (par_mode_r != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BW'(1);
                    end
                end else if (sample_tick) begin
                    tick_cnt_s = tick_cnt_r + TW'(1);
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            ST_PARITY: begin
                if (sample_tick && (tick_cnt_r == BIT_LAST)) begin
                    state_s    = ST_STOP;
                    tick_cnt_s = {TW{1'b0}};
                end else if (sample_tick) begin
                    tick_cnt_s = tick_cnt_r + TW'(1);
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            ST_STOP: begin
                if (sample_tick && (tick_cnt_r == stop_last_s)) begin
                    state_s    = ST_IDLE;
                    tick_cnt_s = {TW{1'b0}};
                    done_s     = 1'b1;
                end else if (sample_tick) begin
                    tick_cnt_s = tick_cnt_r + TW'(1);
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            ST_BREAK: begin
                if (!break_req) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BREAK;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // The line register follows the level of the state being entered.
        case (state_s)
            ST_IDLE:   tx_s = 1'b1;
            ST_START:  tx_s = 1'b0;
            ST_DATA:   tx_s = shift_s[0];
            ST_PARITY: tx_s = parity_bit(par_mode_s, 9'(word_s));
            ST_STOP:   tx_s = 1'b1;
            ST_BREAK:  tx_s = 1'b0;
            default:   tx_s = 1'b1;
        endcase
    end

    // State, counters, latched frame configuration and the registered line.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= {TW{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            shift_r    <= {DBITS{1'b0}};
            word_r     <= {DBITS{1'b0}};
            par_mode_r <= PAR_NONE;
            stop2_r    <= 1'b0;
            tx_r       <= 1'b1;
        end else begin
            state_r    <= state_s;
            tick_cnt_r <= tick_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            word_r     <= word_s;
            par_mode_r <= par_mode_s;
            stop2_r    <= stop2_s;
            tx_r       <= tx_s;
        end
    end

    assign tx        = tx_r;
    assign tx_ready  = ready_s && !reset;
    assign tx_done   = done_s && !reset;
    assign busy      = (state_r != ST_IDLE);
    assign state_out = state_r;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: an 8-bit and a 7-bit instance share
// clock, tick, reset and configuration. Expected frames are queued when a
// word is accepted and compared bit by bit by a mid-bit sampling receiver.
module tb_uart_tx_cfg;
    import uart_pkg::*;

    typedef struct {
        logic [12:0] bits;
        int          n;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_tick;
    logic [1:0] div = 2'd0;
    logic       tx_valid8 = 1'b0, tx_valid7 = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [1:0] parity_mode = 2'b00;
    logic       stop2 = 1'b0;
    logic       break_req = 1'b0;
    logic       tx8, tx_ready8, tx_done8, busy8;
    logic       tx7, tx_ready7, tx_done7, busy7;
    logic [2:0] state8, state7;

    int n_tests = 0, n_fail = 0;
    int done8 = 0, done7 = 0, exp8 = 0, exp7 = 0;
    frame_t q8[$];
    frame_t q7[$];

    uart_tx_cfg #(.DBITS(8), .OVERSAMPLE(16)) dut8 (
        .clk_100MHz(clk), .reset(reset), .sample_tick(sample_tick),
        .tx_valid(tx_valid8), .tx_ready(tx_ready8), .data_in(data_in),
        .parity_mode(parity_mode), .stop2(stop2), .break_req(break_req),
        .tx(tx8), .tx_done(tx_done8), .busy(busy8), .state_out(state8)
    );

    uart_tx_cfg #(.DBITS(7), .OVERSAMPLE(16)) dut7 (
        .clk_100MHz(clk), .reset(reset), .sample_tick(sample_tick),
        .tx_valid(tx_valid7), .tx_ready(tx_ready7), .data_in(data_in[6:0]),
        .parity_mode(parity_mode), .stop2(stop2), .break_req(break_req),
        .tx(tx7), .tx_done(tx_done7), .busy(busy7), .state_out(state7)
    );

    always #5 clk = ~clk;

    // Baud generator stand-in: one tick every 4 clocks.
    always @(posedge clk) div <= div + 2'd1;
    assign sample_tick = (div == 2'd3);

    // Count tx_done pulses per instance.
    always @(negedge clk) begin
        if (tx_done8 === 1'b1) done8 <= done8 + 1;
        if (tx_done7 === 1'b1) done7 <= done7 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic line(input int sel);
        return (sel == 0) ? tx8 : tx7;
    endfunction

    function automatic logic done_sig(input int sel);
        return (sel == 0) ? tx_done8 : tx_done7;
    endfunction

    function automatic logic ready_sig(input int sel);
        return (sel == 0) ? tx_ready8 : tx_ready7;
    endfunction

    // Reference frame: start, data LSB-first, optional parity, stop bit(s).
    function automatic frame_t build(input logic [8:0] data, input int dbits,
                                     input logic [1:0] mode, input logic s2);
        frame_t f;
        int ones;
        f.bits = '0;
        f.bits[0] = 1'b0;
        f.n = 1;
        ones = 0;
        for (int i = 0; i < dbits; i++) begin
            f.bits[f.n] = data[i];
            f.n++;
            if (data[i]) ones++;
        end
        if (mode != 2'b00) begin
            if (mode == 2'b11)      f.bits[f.n] = 1'b1;
            else if (mode == 2'b01) f.bits[f.n] = ((ones % 2) == 1);
            else                    f.bits[f.n] = ((ones % 2) == 0);
            f.n++;
        end
        f.bits[f.n] = 1'b1;
        f.n++;
        if (s2) begin
            f.bits[f.n] = 1'b1;
            f.n++;
        end
        return f;
    endfunction

    // Hand one word to an instance, queue its expected frame, then scramble the inputs.
    task automatic send(input int sel, input logic [8:0] data, input logic [1:0] mode, input logic s2);
        bit ok;
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (ready_sig(sel) === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        data_in     = data[7:0];
        parity_mode = mode;
        stop2       = s2;
        if (sel == 0) tx_valid8 = 1'b1; else tx_valid7 = 1'b1;
        @(posedge clk);
        #1;
        tx_valid8 = 1'b0;
        tx_valid7 = 1'b0;
        if (sel == 0) begin
            q8.push_back(build(data, 8, mode, s2));
            exp8++;
        end else begin
            q7.push_back(build(data, 7, mode, s2));
            exp7++;
        end
        data_in     = ~data[7:0];
        parity_mode = ~mode;
        stop2       = ~s2;
    endtask

    // Receive one frame: detect the start edge, sample mid-bit, time the tx_done pulse.
    task automatic rx(input int sel);
        frame_t f;
        int c, bi, dur;
        bit seen, got_done;
        seen = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (line(sel) === 1'b0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            check("start_timeout", 32'd0, 32'd1);
            return;
        end
        if ((sel == 0 && q8.size() == 0) || (sel != 0 && q7.size() == 0)) begin
            check("queue_empty", 32'd0, 32'd1);
            return;
        end
        if (sel == 0) f = q8.pop_front(); else f = q7.pop_front();
        c = 0; bi = 0; dur = 0; got_done = 0;
        while (!got_done && c < 64 * f.n + 64) begin
            @(negedge clk);
            c++;
            if (bi < f.n && c == 30 + 64 * bi) begin
                check($sformatf("bit%0d", bi), 32'(line(sel)), 32'(f.bits[bi]));
                bi++;
            end
            if (done_sig(sel) === 1'b1) begin
                got_done = 1;
                dur = c;
            end
        end
        check("bits_seen", 32'(bi), 32'(f.n));
        check("frame_len", 32'(dur >= 64 * f.n - 5 && dur <= 64 * f.n), 32'd1);
        @(negedge clk);
        check("done_once", 32'(done_sig(sel)), 32'd0);
        check("idle_tx", 32'(line(sel)), 32'd1);
        check("ready_after", 32'(ready_sig(sel)), 32'd1);
    endtask

    initial begin
        int bad;
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx8), 32'd1);
        check("rst_ready", 32'(tx_ready8), 32'd0);
        check("rst_done", 32'(tx_done8), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_state", 32'(state8), 32'(ST_IDLE));
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(tx_ready8), 32'd1);

        // 8N1 0xA5.
        send(0, 9'h0A5, PAR_NONE, 1'b0);
        rx(0);

        // Parity modes on 0x55 (inputs are scrambled after each accept).
        send(0, 9'h055, PAR_EVEN, 1'b0);
        rx(0);
        send(0, 9'h055, PAR_ODD, 1'b0);
        rx(0);
        send(0, 9'h055, PAR_MARK, 1'b0);
        rx(0);

        // Two stop bits, back-to-back 0x00 then 0xFF.
        fork
            begin
                send(0, 9'h000, PAR_NONE, 1'b1);
                send(0, 9'h0FF, PAR_NONE, 1'b1);
            end
            begin
                rx(0);
                rx(0);
            end
        join

        // 7-bit instance, 0x41 with odd parity.
        send(1, 9'h041, PAR_ODD, 1'b0);
        rx(1);

        // Break for 500 clocks with a competing tx_valid.
        @(negedge clk);
        break_req = 1'b1;
        tx_valid8 = 1'b1;
        data_in   = 8'h5A;
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx8 !== 1'b0 || tx_ready8 !== 1'b0 || state8 !== 3'(ST_BREAK)) bad++;
        end
        check("break_hold", 32'(bad), 32'd0);
        break_req = 1'b0;
        tx_valid8 = 1'b0;
        @(negedge clk);
        check("break_exit_tx", 32'(tx8), 32'd1);
        check("break_exit_state", 32'(state8), 32'(ST_IDLE));

        // Reset during data bit 3 aborts the frame without tx_done.
        send(0, 9'h0C3, PAR_EVEN, 1'b0);
        repeat (64 * 4 + 30) @(negedge clk);
        check("mid_state", 32'(state8), 32'(ST_DATA));
        reset = 1'b1;
        @(negedge clk);
        check("abort_tx", 32'(tx8), 32'd1);
        check("abort_state", 32'(state8), 32'(ST_IDLE));
        check("abort_ready", 32'(tx_ready8), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        if (q8.size() > 0) void'(q8.pop_front());
        exp8--;
        repeat (200) @(negedge clk);
        check("abort_tx_idle", 32'(tx8), 32'd1);

        // Clean frame after the abort.
        send(0, 9'h03C, PAR_ODD, 1'b1);
        rx(0);

        repeat (10) @(negedge clk);
        check("done_cnt8", 32'(done8), 32'(exp8));
        check("done_cnt7", 32'(done7), 32'(exp7));
        check("end_busy7", 32'(busy7), 32'd0);
        check("end_state7", 32'(state7), 32'(ST_IDLE));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "time limit");
    end

endmodule
